// File: rtl/galaga_pkg.sv
// Shared types and helpers for the Galaga pause/hiscore scheduling logic.
package galaga_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    GRANTED = 2'd2,
    RELEASE = 2'd3
  } hs_state_t;

  localparam int R_W = 3;
  localparam int G_W = 3;
  localparam int B_W = 2;

  // Halve each colour field on its own so no bit crosses into its neighbour.
  function automatic logic [7:0] rgb_dim(input logic [7:0] rgb);
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
    r = rgb[G_W+B_W +: R_W];
    g = rgb[B_W +: G_W];
    b = rgb[0 +: B_W];
    return {r >> 1, g >> 1, b >> 1};
  endfunction

endpackage

// File: rtl/pause_dim_timer.sv
// Saturating idle counter; dim asserts once the enable has been held DIM_TICKS cycles.
// Dropping the enable clears the count and drops dim on the next edge.
module pause_dim_timer #(
  parameter int               CNT_W     = 32,
  parameter logic [CNT_W-1:0] DIM_TICKS = CNT_W'(32'h0ABA9500)
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic en,
  output logic dim
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      dim <= 1'b0;
    end else if (en) begin
      if (cnt < DIM_TICKS) begin
        cnt <= cnt + CNT_W'(1);
      end
      dim <= (cnt >= DIM_TICKS);
    end else begin
      cnt <= '0;
      dim <= 1'b0;
    end
  end

endmodule

// File: rtl/pause_ctrl.sv
// Merges user, OSD and hiscore pause sources into one registered pause, runs the
// hiscore req/gnt handshake behind a settle delay, and dims video on long user pauses.
module pause_ctrl
  import galaga_pkg::*;
#(
  parameter int               CNT_W       = 32,
  parameter logic [CNT_W-1:0] DIM_TICKS   = CNT_W'(32'h0ABA9500),
  parameter int               GRANT_DELAY = 4
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       btn_pause,
  input  logic       osd_open,
  input  logic       osd_pause_en,
  input  logic       hs_req,
  output logic       hs_gnt,
  output logic       pause,
  output logic       user_paused,
  output logic       dim_video,
  input  logic [7:0] rgb_in,
  output logic [7:0] rgb_out
);

  localparam logic [7:0] SETTLE_LAST = 8'(GRANT_DELAY - 1);

  hs_state_t  state;
  hs_state_t  next_state;
  logic [7:0] settle_cnt;
  logic       btn_q;
  logic       btn_armed;
  logic       btn_rise;
  logic       user_paused_next;
  logic       hs_gnt_d;
  logic       pause_d;

  // A button already held when reset lifts is not a press; it must be released first.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      btn_q     <= 1'b0;
      btn_armed <= 1'b0;
    end else begin
      btn_q     <= btn_pause;
      btn_armed <= 1'b1;
    end
  end

  assign btn_rise         = btn_pause & ~btn_q & btn_armed;
  assign user_paused_next = user_paused ^ btn_rise;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      settle_cnt <= '0;
    end else if (state == SETTLE) begin
      settle_cnt <= settle_cnt + 8'd1;
    end else begin
      settle_cnt <= '0;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (hs_req) next_state = SETTLE;
      SETTLE: begin
        if (!hs_req) begin
          next_state = IDLE;
        end else if (settle_cnt == SETTLE_LAST) begin
          next_state = GRANTED;
        end
      end
      GRANTED: if (!hs_req) next_state = RELEASE;
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    hs_gnt_d = (next_state == GRANTED);
    pause_d  = user_paused_next | (osd_open & osd_pause_en) | (next_state != IDLE);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hs_gnt      <= 1'b0;
      pause       <= 1'b0;
      user_paused <= 1'b0;
      rgb_out     <= '0;
    end else begin
      hs_gnt      <= hs_gnt_d;
      pause       <= pause_d;
      user_paused <= user_paused_next;
      rgb_out     <= dim_video ? rgb_dim(rgb_in) : rgb_in;
    end
  end

  pause_dim_timer #(
    .CNT_W     (CNT_W),
    .DIM_TICKS (DIM_TICKS)
  ) u_dim_timer (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .en      (user_paused),
    .dim     (dim_video)
  );

endmodule
